// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per cycle, LSB first.
// Optional signed-overflow output ovf is built when SERIAL_SUB_SIGNED_OVF_EN is defined.
module serial_subtractor #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE:0]   result,
    output logic            busy,
    output logic            done
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic            br_reg;
    logic [SIZE-1:0] a_reg, b_reg, diff_reg;
    logic [SIZE:0]   result_reg;

    logic            a_bit, b_bit, d_bit, br_next, last_bit;
    logic [SIZE-1:0] diff_next;

    assign a_bit    = a_reg[cnt_reg];
    assign b_bit    = b_reg[cnt_reg];
    assign d_bit    = a_bit ^ b_bit ^ br_reg;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);
    assign last_bit = (cnt_reg == LAST);

    // The difference bit lands directly at its final position so that the
    // completed word is available combinationally on the last RUN cycle.
    always_comb begin
        diff_next          = diff_reg;
        diff_next[cnt_reg] = d_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            br_reg     <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        cnt_reg <= '0;
                        br_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    diff_reg <= diff_next;
                    br_reg   <= br_next;
                    if (last_bit) begin
                        result_reg <= {br_next, diff_next};
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic ovf_reg;

    // On the last bit a_bit/b_bit are the operand sign bits and d_bit the result sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_bit) begin
            ovf_reg <= (a_bit != b_bit) && (d_bit != a_bit);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign result = result_reg;
    assign busy   = (state_reg == RUN);
    assign done   = (state_reg == DONE);

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter SIZE, default 4, which sets the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port start, input, 1 bit: request a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a, input, SIZE bits: minuend, unsigned.
REQ-006 SHALL have port b, input, SIZE bits: subtrahend, unsigned.
REQ-007 SHALL have port result, output, SIZE+1 bits: {borrow_out, difference}, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse, high while in DONE.
REQ-010 SHALL have port ovf, output, 1 bit, present only when the Configuration macro is defined.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE, encoded in registers.
REQ-012 SHALL, in IDLE with start=1 at a rising edge: latch a and b into internal operand registers, clear the bit counter and the borrow register, and move to RUN.
REQ-013 SHALL, in IDLE with start=0, stay in IDLE; result holds its last value.
REQ-014 SHALL, in RUN, process one bit per cycle, LSB first, with bit index i equal to the counter value.
REQ-015 SHALL compute each bit as d_i = a_i XOR b_i XOR br.
REQ-016 SHALL update the borrow as br' = (~a_i & b_i) | (~(a_i XOR b_i) & br).
REQ-017 SHALL use a borrow-in of 0 for bit 0.
REQ-018 SHALL shift d_i into an internal SIZE-bit difference register, so that bit i ends at position i.
REQ-019 SHALL, on the SIZE-th RUN edge (counter = SIZE-1), write result = {br', completed difference}, move to DONE, and not wrap the counter further.
REQ-020 SHALL stay in DONE for exactly one cycle, then go to IDLE unconditionally.
REQ-021 SHALL give latency as follows: start is accepted at edge E0; done is high in the cycle following edge E(SIZE); the minimum issue interval is SIZE+2 cycles.
REQ-022 SHALL ignore start in RUN and DONE (no queuing); operands captured at E0 are unaffected by later changes on a and b.
REQ-023 SHALL make result equal to the (SIZE+1)-bit two's-complement value a-b; borrow_out=1 exactly when a<b.
REQ-024 SHALL keep result stable except at the RUN->DONE edge; result never shows partial values.
REQ-025 SHALL keep busy and done mutually exclusive; both are 0 in IDLE.

Reset
REQ-026 SHALL, while rst_n=0, immediately force the state to IDLE, busy=0, done=0, result=0, counter=0, borrow=0, and ovf=0 where ovf is present.
REQ-027 SHALL, when rst_n asserts mid-RUN, abandon the operation with no done pulse; the first start after release begins a fresh operation.
REQ-028 SHALL act on start at the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with SERIAL_SUB_SIGNED_OVF_EN defined, provide output ovf, registered together with result: ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), which is signed two's-complement overflow of a-b in SIZE bits; ovf holds until the next completion.
REQ-030 SHALL, with SERIAL_SUB_SIGNED_OVF_EN undefined, have no ovf port and no ovf logic; all other behaviour is identical.

Verification (SIZE=4)
REQ-031 SHALL cover: a=9, b=3, start pulse -> busy for 4 cycles, then done for 1 cycle, result=5'b0_0110.
REQ-032 SHALL cover: a=3, b=9 -> result=5'b1_1010 (borrow=1, difference=-6 mod 16).
REQ-033 SHALL cover: a=15, b=15, then a=0, b=0, issued back-to-back at the earliest IDLE -> result=5'b0_0000 both times, with done pulses 6 cycles apart.
REQ-034 SHALL cover: start held high continuously, with a and b changed during RUN -> a single done per 6 cycles; each result matches the operands at the accepting edge.
REQ-035 SHALL cover: rst_n pulsed low at RUN cycle 2 -> busy, done and result go to 0 asynchronously; no done pulse; the next operation a=5, b=2 gives result=5'b0_0011.
REQ-036 SHALL cover, with SERIAL_SUB_SIGNED_OVF_EN defined: a=4'b0111, b=4'b1000 -> ovf=1; a=4'b0101, b=4'b0011 -> ovf=0.
